// File: rtl/enet_arb_pkg.sv
// Shared definitions for the Ethernet TX round-robin arbiter: header
// layout, magic byte and the scheduler state encoding.
package enet_arb_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  // Routing header field positions within the 64-bit header beat.
  localparam int HDR_MAGIC_LSB = 56;
  localparam int HDR_IDX_LSB   = 48;
  localparam int HDR_SEQ_LSB   = 32;
  localparam int HDR_LEN_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  // Assemble the one-beat routing header that precedes each packet.
  function automatic logic [63:0] build_hdr(input logic [7:0]  idx,
                                            input logic [15:0] seq,
                                            input logic [31:0] len);
    logic [63:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8]  = HDR_MAGIC;
    h[HDR_IDX_LSB   +: 8]  = idx;
    h[HDR_SEQ_LSB   +: 16] = seq;
    h[HDR_LEN_LSB   +: 32] = len;
    return h;
  endfunction

endpackage

// File: rtl/enet_rr_pick.sv
// Combinational round-robin picker: searches upward from last_i+1,
// wrapping modulo NUM_REQ, and reports the first set request bit.
module enet_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [$clog2(NUM_REQ)-1:0] win_o,
  output logic                       any_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Priority scan starting just after the previous owner.
  always_comb begin
    int   idx;
    logic found;
    found = 1'b0;
    win_o = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_i) + k) % NUM_REQ;
      if (!found && req_i[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        win_o = idx[IDX_W-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/enet_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the Ethernet TX FIFO
// write port. Each grant emits a routing header beat, then exactly
// PKT_BEATS data beats from the owner, then one idle gap cycle.
module enet_tx_arbiter
  import enet_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PKT_BEATS = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ*64-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [63:0]           o_data,
  output logic                  o_valid,
  input  logic                  i_rdy,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic                  o_busy,
  output logic [15:0]           o_pkt_cnt
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(PKT_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_BEATS - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [15:0]        seq_q, seq_d;
  logic [15:0]        pkt_q, pkt_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;

  logic [IDX_W-1:0]   win;
  logic               any;
  logic [63:0]        sel_data;
  logic               sel_valid;

  enet_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (i_req),
    .last_i (last_q),
    .win_o  (win),
    .any_o  (any)
  );

  // Route the current owner's beat and valid onto the shared port.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (gidx_q == IDX_W'(n)) begin
        sel_data  = i_req_data[64*n +: 64];
        sel_valid = i_req_valid[n];
      end
    end
  end

  // Next-state, counter updates and port outputs for the scheduler.
  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    grant_d     = grant_q;
    seq_d       = seq_q;
    pkt_d       = pkt_q;
    beat_d      = beat_q;
    o_data      = '0;
    o_valid     = 1'b0;
    o_req_ready = '0;
    case (state_q)
      IDLE: begin
        if (i_enable && any) begin
          state_d = HDR;
          gidx_d  = win;
          grant_d = NUM_REQ'(1) << win;
        end
      end
      HDR: begin
        o_valid = 1'b1;
        o_data  = build_hdr(8'(gidx_q), seq_q, 32'(PKT_BEATS));
        if (i_rdy) begin
          state_d = DATA;
        end
      end
      DATA: begin
        o_data              = sel_data;
        o_valid             = sel_valid;
        o_req_ready[gidx_q] = i_rdy;
        if (sel_valid && i_rdy) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        seq_d   = seq_q + 16'd1;
        pkt_d   = pkt_q + 16'd1;
        last_d  = gidx_q;
        grant_d = '0;
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; last owner starts at the top index so
  // requester 0 is favoured after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      seq_q   <= '0;
      pkt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      seq_q   <= seq_d;
      pkt_q   <= pkt_d;
      beat_q  <= beat_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_busy    = (state_q != IDLE);
  assign o_pkt_cnt = pkt_q;

endmodule

// File: tb/tb_enet_tx_arbiter.sv
// Self-checking bench for enet_tx_arbiter: a packet-level scoreboard
// predicts owner, header, data order and control outputs every cycle.
module tb_enet_tx_arbiter;

  localparam int NR = 4;
  localparam int PB = 128;
  localparam int PH_IDLE = 0, PH_HDR = 1, PH_DATA = 2, PH_GAP = 3;

  logic           i_clk = 1'b0;
  logic           i_rst_n, i_enable, i_rdy;
  logic [NR-1:0]  i_req, i_req_valid, o_req_ready, o_grant;
  logic [NR*64-1:0] i_req_data;
  logic [63:0]    o_data;
  logic           o_valid, o_busy;
  logic [15:0]    o_pkt_cnt;

  always #5 i_clk = ~i_clk;

  enet_tx_arbiter #(.NUM_REQ(NR), .PKT_BEATS(PB)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_enable    (i_enable),
    .i_req       (i_req),
    .i_req_data  (i_req_data),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_rdy       (i_rdy),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_pkt_cnt   (o_pkt_cnt)
  );

  int n_vec = 0, n_err = 0;
  int m_phase, m_owner, m_last, m_beats, m_stall;
  logic [15:0] m_seq, m_pkt;
  int m_exp [NR];
  int src_cnt [NR];
  logic [NR-1:0] hs_q;
  bit rdy_rand;
  int gap_left;
  int hdr_owner, hdr_seq;

  typedef struct {
    logic [NR-1:0] req;
    bit            rnd;
    int            exp_owner;
    int            exp_seq;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [63:0] word(input int n, input int k);
    return {8'(n), 8'hC3, 48'(k)};
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic logic [63:0] ctrl_word(input logic b, input logic [NR-1:0] g,
                                            input logic v, input logic [NR-1:0] r,
                                            input logic [15:0] p);
    return {38'b0, b, g, v, r, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [63:0]   act;
    logic [NR-1:0] eg, er;
    logic          ev;
    for (int n = 0; n < NR; n++) hs_q[n] = o_req_ready[n] & i_req_valid[n];
    act = ctrl_word(o_busy, o_grant, o_valid, o_req_ready, o_pkt_cnt);
    case (m_phase)
      PH_IDLE: begin
        chk("idle_ctrl", act, ctrl_word(1'b0, '0, 1'b0, '0, m_pkt));
        if (i_enable && i_req != '0) begin
          m_owner = rr_pick(i_req, m_last);
          m_phase = PH_HDR;
        end
      end
      PH_HDR: begin
        eg = NR'(1) << m_owner;
        chk("hdr_ctrl", act, ctrl_word(1'b1, eg, 1'b1, '0, m_pkt));
        chk("hdr_data", o_data, {8'hA5, 8'(m_owner), m_seq, 32'(PB)});
        if (i_rdy) begin
          hdr_owner = int'(o_data[55:48]);
          hdr_seq   = int'(o_data[47:32]);
          m_phase = PH_DATA;
          m_beats = 0;
          m_stall = 0;
        end
      end
      PH_DATA: begin
        eg = NR'(1) << m_owner;
        ev = i_req_valid[m_owner];
        er = i_rdy ? eg : '0;
        chk("data_ctrl", act, ctrl_word(1'b1, eg, ev, er, m_pkt));
        chk("data_beat", o_data, word(m_owner, m_exp[m_owner]));
        if (!ev) m_stall++;
        if (ev && i_rdy) begin
          m_exp[m_owner]++;
          m_beats++;
          if (m_beats == PB) m_phase = PH_GAP;
        end
      end
      default: begin
        chk("gap_ctrl", ctrl_word(o_busy, '0, o_valid, o_req_ready, o_pkt_cnt),
            ctrl_word(1'b1, '0, 1'b0, '0, m_pkt));
        m_seq   = m_seq + 16'd1;
        m_pkt   = m_pkt + 16'd1;
        m_last  = m_owner;
        m_phase = PH_IDLE;
      end
    endcase
  endtask

  task automatic drive();
    for (int n = 0; n < NR; n++) if (hs_q[n]) src_cnt[n]++;
    for (int n = 0; n < NR; n++) begin
      i_req_data[64*n +: 64] = word(n, src_cnt[n]);
      i_req_valid[n] = 1'b1;
    end
    if (gap_left > 0 && m_phase == PH_DATA && m_beats == 64) begin
      i_req_valid[m_owner] = 1'b0;
      gap_left--;
    end
    i_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic step();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
    drive();
  endtask

  task automatic bound(input string name, input bit expired);
    n_vec++;
    if (expired) begin
      n_err++;
      $display("FAIL %s: wait budget expired, required the event to occur", name);
    end
  endtask

  task automatic wait_grant();
    int c = 0;
    while (m_phase == PH_IDLE && c < 20) begin step(); c++; end
    bound("wait_grant", m_phase == PH_IDLE);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (m_phase != PH_IDLE && c < 2000) begin step(); c++; end
    bound("wait_idle", m_phase != PH_IDLE);
  endtask

  task automatic wait_beat(input int b);
    int c = 0;
    while (!(m_phase == PH_DATA && m_beats >= b) && c < 1000) begin step(); c++; end
    bound("wait_beat", !(m_phase == PH_DATA && m_beats >= b));
  endtask

  task automatic run_pkt(input logic [NR-1:0] r);
    i_req = r;
    i_enable = 1'b1;
    hdr_owner = -1;
    hdr_seq = -1;
    wait_grant();
    i_req = '0;
    wait_idle();
  endtask

  initial begin
    tbl[0] = '{4'b0001, 1'b0, 0, 0};
    tbl[1] = '{4'b1111, 1'b0, 1, 1};
    tbl[2] = '{4'b1111, 1'b0, 2, 2};
    tbl[3] = '{4'b1111, 1'b0, 3, 3};
    tbl[4] = '{4'b1111, 1'b0, 0, 4};
    tbl[5] = '{4'b0100, 1'b0, 2, 5};
    tbl[6] = '{4'b0110, 1'b0, 1, 6};
    tbl[7] = '{4'b1001, 1'b0, 3, 7};
    tbl[8] = '{4'b1001, 1'b1, 0, 8};
    tbl[9] = '{4'b0010, 1'b1, 1, 9};

    m_phase = PH_IDLE; m_last = NR - 1; m_seq = '0; m_pkt = '0;
    m_owner = 0; m_beats = 0; m_stall = 0;
    for (int n = 0; n < NR; n++) begin m_exp[n] = 0; src_cnt[n] = 0; end
    hs_q = '0; rdy_rand = 1'b0; gap_left = 0;
    i_rst_n = 1'b0; i_enable = 1'b0; i_req = '0;
    drive();
    #1;
    chk("reset_ctrl", ctrl_word(o_busy, o_grant, o_valid, o_req_ready, o_pkt_cnt), 64'd0);
    chk("reset_data", o_data, 64'd0);
    step();
    step();
    i_rst_n = 1'b1;
    step();

    // Table of packets: expected owner and header sequence per grant.
    for (int i = 0; i < 10; i++) begin
      rdy_rand = tbl[i].rnd;
      run_pkt(tbl[i].req);
      chk("tbl_owner", 64'(hdr_owner), 64'(tbl[i].exp_owner));
      chk("tbl_seq", 64'(hdr_seq), 64'(tbl[i].exp_seq));
      if (i == 0) chk("pkt_cnt_after_first", 64'(o_pkt_cnt), 64'd1);
    end
    rdy_rand = 1'b0;

    // Enable dropped mid-packet: packet completes, no new grant while low.
    i_req = 4'b0100;
    i_enable = 1'b1;
    wait_grant();
    wait_beat(10);
    i_enable = 1'b0;
    wait_idle();
    for (int c = 0; c < 20; c++) step();
    chk("en_low_grant", 64'(o_grant), 64'd0);
    chk("en_low_busy", 64'(o_busy), 64'd0);
    chk("en_drop_pkt_cnt", 64'(o_pkt_cnt), 64'd11);
    run_pkt(4'b0100);
    chk("en_back_owner", 64'(hdr_owner), 64'd2);
    chk("en_back_seq", 64'(hdr_seq), 64'd11);

    // Requester valid gap of 20 cycles at beat 64.
    gap_left = 20;
    run_pkt(4'b1000);
    chk("gap_owner", 64'(hdr_owner), 64'd3);
    chk("gap_stall_cycles", 64'(m_stall), 64'd20);
    chk("gap_consumed", 64'(gap_left), 64'd0);

    // Asynchronous reset at beat 50.
    i_req = 4'b1111;
    i_enable = 1'b1;
    wait_grant();
    i_req = '0;
    wait_beat(50);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", ctrl_word(o_busy, o_grant, o_valid, o_req_ready, o_pkt_cnt), 64'd0);
    chk("midrst_data", o_data, 64'd0);
    m_phase = PH_IDLE; m_last = NR - 1; m_seq = '0; m_pkt = '0;
    step();
    step();
    i_rst_n = 1'b1;
    run_pkt(4'b1111);
    chk("post_rst_owner", 64'(hdr_owner), 64'd0);
    chk("post_rst_seq", 64'(hdr_seq), 64'd0);

    // Random request patterns with 50% downstream ready.
    rdy_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [NR-1:0] r;
      int exp_o;
      r = NR'($urandom_range(1, 15));
      exp_o = rr_pick(r, m_last);
      run_pkt(r);
      chk("rand_owner", 64'(hdr_owner), 64'(exp_o));
    end
    rdy_rand = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
